// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: async FIFO read side to valid/ready stream via a 3-entry credit buffer.
// Define FIFO_RD_CNT_EN to add the 16-bit pop_cnt output.
module fifo_rd_stream #(
  parameter int DATESIZE = 8,
  parameter int BUFDEPTH = 3
) (
  input  logic                rclk,
  input  logic                r_rstn,
  input  logic                rempty,
  input  logic [DATESIZE-1:0] rdata,
  output logic                rinc,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATESIZE-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]         pop_cnt
`endif
);
  logic [DATESIZE-1:0] mem [BUFDEPTH];
  logic [1:0] head, tail, occ;
  logic inflight, xfer;
  // Credits count words already buffered plus the one whose rdata arrives next cycle
  assign rinc = r_rstn && !rempty && (3'(occ) + 3'(inflight) < 3'(BUFDEPTH));
  assign m_valid = occ != 2'd0;
  assign m_data = mem[head];
  assign xfer = m_valid && m_ready;
  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      mem <= '{default: '0};
      head <= 2'd0;
      tail <= 2'd0;
      occ <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rinc;
      if (inflight) begin
        mem[tail] <= rdata;
        tail <= tail == 2'd2 ? 2'd0 : tail + 2'd1;
      end
      if (xfer) head <= head == 2'd2 ? 2'd0 : head + 2'd1;
      occ <= occ + 2'(inflight) - 2'(xfer);
    end
  end
`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) pop_cnt <= 16'd0;
    else pop_cnt <= pop_cnt + 16'(rinc);
  end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized bench for fifo_rd_stream against a pop-order scoreboard model.
// Define FIFO_RD_CNT_EN to also exercise pop_cnt and its wrap.
module tb_fifo_rd_stream;
  logic       rclk = 1'b0;
  logic       r_rstn = 1'b0;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc, m_valid, m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] pop_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] src[$];
  logic [7:0] sb[$];
  logic       last_pop = 1'b0;
  logic [15:0] cnt = 16'd0;

  fifo_rd_stream #(.DATESIZE(8), .BUFDEPTH(3)) dut (
    .rclk(rclk), .r_rstn(r_rstn), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FIFO_RD_CNT_EN
    , .pop_cnt(pop_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // sb holds every word popped but not yet delivered; the newest is still in flight for one cycle
  task automatic step();
    logic pop, exp_valid, xfer;
    @(negedge rclk);
    pop = !rempty && sb.size() < 3;
    exp_valid = sb.size() > int'(last_pop);
    chk("rinc", rinc, pop);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid) chk("m_data", m_data, sb[0]);
    xfer = exp_valid && m_ready;
    @(posedge rclk);
    #1;
    if (xfer) void'(sb.pop_front());
    if (pop) begin
      rdata = src.pop_front();
      sb.push_back(rdata);
      cnt++;
    end
    last_pop = pop;
    if (src.size() == 0) rempty = 1'b1;
`ifdef FIFO_RD_CNT_EN
    chk("pop_cnt", pop_cnt, cnt);
`endif
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((src.size() != 0 || sb.size() != 0) && n < max_cycles) begin
      rempty = src.size() == 0;
      step();
      n++;
    end
    chk("drain_done", n < max_cycles, 1'b1);
  endtask

  task automatic do_reset();
    r_rstn = 1'b0;
    #1;
    chk("rst_rinc", rinc, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    sb.delete();
    last_pop = 1'b0;
    cnt = 16'd0;
    @(posedge rclk);
    #1;
    r_rstn = 1'b1;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) src.push_back(base + 8'(i * 17));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rempty = 1'b0;
    do_reset();
    rempty = 1'b1;
    for (int i = 0; i < 8; i++) step();
    // four words streamed with the sink always ready
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 1'b1;
    drain(20);
    // five words against a stalled sink, then released
    load(5, 8'h50);
    m_ready = 1'b0;
    rempty = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("stall_buffered", sb.size(), 3);
    m_ready = 1'b1;
    drain(20);
    // single word, then empty
    src.push_back(8'hA5);
    drain(10);
    for (int i = 0; i < 4; i++) step();
    // reset with two buffered words and one in flight
    load(6, 8'h80);
    m_ready = 1'b0;
    rempty = 1'b0;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    rempty = src.size() == 0;
    m_ready = 1'b1;
    drain(20);
    // randomized traffic with a refilling source
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) src.push_back(8'($urandom));
      rempty = src.size() == 0 || $urandom_range(0, 3) == 0;
      m_ready = $urandom_range(0, 2) != 0;
      step();
    end
    m_ready = 1'b1;
    drain(200);
`ifdef FIFO_RD_CNT_EN
    do_reset();
    for (int i = 0; i < 65534; i++) src.push_back(8'($urandom));
    drain(70000);
    chk("cnt_fffe", pop_cnt, 16'hFFFE);
    load(3, 8'hC0);
    drain(20);
    chk("cnt_wrap", pop_cnt, 16'h0001);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
